ieu_rom_bist: RTL

Built-in self-test controller that reads the IEU microcode ROM through its test port. It sweeps every ROM address on the test address bus with test mode asserted and compresses each returned word into a 32-bit MISR signature. It compares the final signature against an expected value and reports pass/fail. It sits beside the IEU ROM shell and drives that shell's `tadr`, `tm` and `me` inputs, consuming its `do[79:0]` output.

---
 rtl/ieu_rom_bist_if.sv | 30 +++
 rtl/ieu_rom_bist.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ieu_rom_bist_if.sv
// ieu_rom_bist_if
// Test-port bus between the ROM BIST controller and the IEU ROM shell.
//   rom_tadr : test address (controller -> ROM)
//   rom_tm   : test-mode select (controller -> ROM)
//   rom_me   : memory enable (controller -> ROM)
//   rom_do   : registered ROM read data (ROM -> controller)
// master = BIST controller side, slave = ROM shell side.
interface ieu_rom_bist_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 80
);
  logic [ADDR_W-1:0] rom_tadr;
  logic              rom_tm;
  logic              rom_me;
  logic [DATA_W-1:0] rom_do;

  modport master (
    output rom_tadr,
    output rom_tm,
    output rom_me,
    input  rom_do
  );

  modport slave (
    input  rom_tadr,
    input  rom_tm,
    input  rom_me,
    output rom_do
  );
endinterface

// File: rtl/ieu_rom_bist.sv
// ieu_rom_bist
// Built-in self-test controller for the IEU microcode ROM. Sweeps every
// address 0..DEPTH-1 through the ROM test port, folds each returned word to
// 32 bits and compresses it into a MISR, then compares the final signature
// with an expected value latched at start.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   bist_start   : start request (accepted in IDLE or DONE only)
//   bist_sig_exp : expected signature, latched on accepted start
//   rom          : ROM test-port bus (tadr/tm/me out, do in)
//   bist_busy    : sweep in progress (RUN, DRAIN)
//   bist_done    : result valid
//   bist_pass    : final signature matched (valid while bist_done)
//   bist_sig     : current MISR contents
// All outputs come straight from registers.
module ieu_rom_bist #(
  parameter int          DEPTH  = 512,
  parameter int          ADDR_W = 9,
  parameter int          DATA_W = 80,
  parameter logic [31:0] SEED   = 32'hFFFF_FFFF,
  parameter logic [31:0] POLY   = 32'h04C1_1DB7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bist_start,
  input  logic [31:0]         bist_sig_exp,
  ieu_rom_bist_if.master      rom,
  output logic                bist_busy,
  output logic                bist_done,
  output logic                bist_pass,
  output logic [31:0]         bist_sig
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // One extra counter bit so DEPTH == 2**ADDR_W is reachable without wrap.
  localparam logic [ADDR_W:0] END_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state_q;
  logic [ADDR_W:0]   addr_q;
  logic [ADDR_W-1:0] tadr_q;
  logic              tm_q;
  logic              me_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              valid_q;
  logic [31:0]       misr_q;
  logic [31:0]       misr_d;
  logic [31:0]       exp_q;
  logic [31:0]       fold;
  logic [95:0]       do_ext;

  // Zero-extend to three 32-bit lanes; the top lane carries do[79:64].
  assign do_ext = 96'(rom.rom_do);

  always_comb begin
    fold   = do_ext[31:0] ^ do_ext[63:32] ^ do_ext[95:64];
    misr_d = {misr_q[30:0], 1'b0} ^ (misr_q[31] ? POLY : 32'h0) ^ fold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tadr_q  <= '0;
      tm_q    <= 1'b0;
      me_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      valid_q <= 1'b0;
      misr_q  <= SEED;
      exp_q   <= '0;
    end else begin
      // The ROM returns data one cycle after it registers the address, so a
      // word driven in RUN is ready for capture one cycle after valid_q rises.
      valid_q <= (state_q == S_RUN);
      if (valid_q) begin
        misr_q <= misr_d;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bist_start) begin
            state_q <= S_RUN;
            tadr_q  <= '0;
            addr_q  <= (ADDR_W+1)'(1);
            misr_q  <= SEED;
            exp_q   <= bist_sig_exp;
            tm_q    <= 1'b1;
            me_q    <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // addr_q holds the next address; once it reaches DEPTH the last
          // address has been on the bus for one cycle and is left there.
          if (addr_q == END_CNT) begin
            state_q <= S_DRAIN;
          end else begin
            tadr_q <= addr_q[ADDR_W-1:0];
            addr_q <= addr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          // Last capture happens on this edge; compare the post-capture value.
          state_q <= S_DONE;
          tm_q    <= 1'b0;
          me_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (misr_d == exp_q);
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rom.rom_tadr = tadr_q;
  assign rom.rom_tm   = tm_q;
  assign rom.rom_me   = me_q;
  assign bist_busy    = busy_q;
  assign bist_done    = done_q;
  assign bist_pass    = pass_q;
  assign bist_sig     = misr_q;

endmodule
